// File: rtl/vga_menu_controller_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA menu controller:
//   - vga_timing_t : horizontal/vertical timing parameter set.
//   - VGA_640X480_60 and DEF_* : default 640x480@60 Hz timing and menu knobs.
//   - menu_state_t : menu/countdown FSM states (2-bit encoding).
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active : 16'd640,
        h_fp     : 16'd16,
        h_sync   : 16'd96,
        h_bp     : 16'd48,
        v_active : 16'd480,
        v_fp     : 16'd10,
        v_sync   : 16'd2,
        v_bp     : 16'd33
    };

    localparam int DEF_CLK_DIV        = 2;
    localparam int DEF_N_OPTIONS      = 9;
    localparam int DEF_DEB_CYCLES     = 250000;
    localparam int DEF_TIMEOUT_FRAMES = 1800;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2,
        TIMEOUT  = 2'd3
    } menu_state_t;

endpackage

// File: rtl/vga_menu_controller_if.sv
// ---------------------------------------------------------------------------
// vga_menu_controller_if
//   Bundles the buttons, VGA pins, pixel coordinates and menu status of the
//   controller. Clock and reset are kept outside the interface.
//   master : the controller (consumes buttons, drives everything else).
//   slave  : board top / pixel generator / bench side.
//   Parameters must match the controller's timing:
//     HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL), SEL_W = $clog2(N_OPTIONS).
//   dbg_state exposes the menu FSM state (menu_state_t encoding).
// ---------------------------------------------------------------------------
interface vga_menu_controller_if #(
    parameter int HW    = 10,
    parameter int VW    = 10,
    parameter int SEL_W = 4
);
    logic             move;
    logic             select;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_CLK;
    logic             VGA_SYNC_N;
    logic             VGA_BLANK_N;
    logic [HW-1:0]    hcount;
    logic [VW-1:0]    vcount;
    logic             frame_start;
    logic [SEL_W-1:0] selected;
    logic             counting;
    logic             finish;
    logic             finish_timeout;
    logic [1:0]       dbg_state;

    modport master (
        input  move, select,
        output VGA_HS, VGA_VS, VGA_CLK, VGA_SYNC_N, VGA_BLANK_N,
        output hcount, vcount, frame_start,
        output selected, counting, finish, finish_timeout, dbg_state
    );

    modport slave (
        output move, select,
        input  VGA_HS, VGA_VS, VGA_CLK, VGA_SYNC_N, VGA_BLANK_N,
        input  hcount, vcount, frame_start,
        input  selected, counting, finish, finish_timeout, dbg_state
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-clock divider, h/v counters, sync/blank generation, frame pulse.
//   Ports:
//     i_clk         system clock (CLOCK_50)
//     i_rst_n       synchronous active-low reset
//     o_hcount      pixel x, 0..H_TOTAL-1
//     o_vcount      pixel y, 0..V_TOTAL-1
//     o_hs, o_vs    syncs, active at HS_POL / VS_POL
//     o_vga_clk     pixel clock, high while divider >= CLK_DIV/2
//     o_blank_n     1 inside the active area
//     o_frame_start one-cycle pulse on the edge h,v wrap to 0,0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_hcount,
    output logic [VW-1:0] o_vcount,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_vga_clk,
    output logic          o_blank_n,
    output logic          o_frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [HW-1:0]    r_h;
    logic [VW-1:0]    r_v;
    logic             r_hs;
    logic             r_vs;
    logic             r_vga_clk;
    logic             r_blank_n;
    logic             r_frame_start;

    logic             w_pix_en;
    logic             w_h_wrap;
    logic             w_frame_wrap;
    logic [DIV_W-1:0] w_div_next;
    logic [HW-1:0]    w_h_next;
    logic [VW-1:0]    w_v_next;

    always_comb begin
        w_pix_en     = (r_div == DIV_LAST);
        w_div_next   = w_pix_en ? '0 : r_div + 1'b1;
        w_h_wrap     = w_pix_en && (r_h == H_LAST);
        w_frame_wrap = w_h_wrap && (r_v == V_LAST);
        w_h_next     = r_h;
        w_v_next     = r_v;
        if (w_pix_en) begin
            w_h_next = w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) begin
                w_v_next = (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end
        end
    end

    // Sync, blank and pixel clock are decoded from the next counter values
    // so that they land on the same edge as hcount/vcount (no skew).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_vga_clk     <= 1'b0;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_vga_clk     <= (w_div_next >= DIV_HALF);
            r_hs          <= ((w_h_next >= HS_START) && (w_h_next <= HS_END)) ? HS_POL : ~HS_POL;
            r_vs          <= ((w_v_next >= VS_START) && (w_v_next <= VS_END)) ? VS_POL : ~VS_POL;
            r_blank_n     <= (w_h_next < H_ACT) && (w_v_next < V_ACT);
            r_frame_start <= w_frame_wrap;
        end
    end

    assign o_hcount      = r_h;
    assign o_vcount      = r_v;
    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_vga_clk     = r_vga_clk;
    assign o_blank_n     = r_blank_n;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_menu_controller.sv
// ---------------------------------------------------------------------------
// vga_menu_controller
//   VGA timing front end plus menu selection and frame-based countdown.
//   Ports:
//     CLOCK_50  system clock
//     reset     synchronous, active-low reset
//     bus       vga_menu_controller_if.master:
//                 move/select (raw buttons, in), VGA_HS/VS/CLK/SYNC_N/BLANK_N,
//                 hcount/vcount, frame_start, selected, counting, finish,
//                 finish_timeout, dbg_state (FSM state) (out)
//   Each button is synchronised, debounced and turned into a one-cycle press
//   event. The FSM cycles the option cursor in IDLE, runs a frame countdown
//   in COUNTING and holds finish / finish_timeout in DONE / TIMEOUT.
// ---------------------------------------------------------------------------
module vga_menu_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int H_ACTIVE       = int'(VGA_640X480_60.h_active),
    parameter int H_FP           = int'(VGA_640X480_60.h_fp),
    parameter int H_SYNC         = int'(VGA_640X480_60.h_sync),
    parameter int H_BP           = int'(VGA_640X480_60.h_bp),
    parameter int V_ACTIVE       = int'(VGA_640X480_60.v_active),
    parameter int V_FP           = int'(VGA_640X480_60.v_fp),
    parameter int V_SYNC         = int'(VGA_640X480_60.v_sync),
    parameter int V_BP           = int'(VGA_640X480_60.v_bp),
    parameter bit HS_POL         = 1'b0,
    parameter bit VS_POL         = 1'b0,
    parameter int N_OPTIONS      = DEF_N_OPTIONS,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    vga_menu_controller_if.master bus
);

    localparam int SEL_W = $clog2(N_OPTIONS);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int FRM_W = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N_OPTIONS - 1);
    localparam logic [DEB_W-1:0] DEB_FULL    = DEB_W'(DEB_CYCLES);
    localparam logic [FRM_W-1:0] FRAMES_LAST = FRM_W'(TIMEOUT_FRAMES - 1);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_COUNTING = COUNTING;
    localparam logic [1:0] ST_DONE     = DONE;
    localparam logic [1:0] ST_TIMEOUT  = TIMEOUT;

    // ---------------------------------------------------------------- timing
    logic w_frame_start;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_timing (
        .i_clk         (CLOCK_50),
        .i_rst_n       (reset),
        .o_hcount      (bus.hcount),
        .o_vcount      (bus.vcount),
        .o_hs          (bus.VGA_HS),
        .o_vs          (bus.VGA_VS),
        .o_vga_clk     (bus.VGA_CLK),
        .o_blank_n     (bus.VGA_BLANK_N),
        .o_frame_start (w_frame_start)
    );

    assign bus.frame_start = w_frame_start;
    assign bus.VGA_SYNC_N  = 1'b0;

    // --------------------------------------------------------------- buttons
    // Index 0 = move, 1 = select.
    logic [1:0] w_btn_pin;
    logic [1:0] w_btn_evt;

    assign w_btn_pin = {bus.select, bus.move};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]       r_sync;    // pressed-polarity synchroniser
        logic             r_last;    // level of the current run of samples
        logic [DEB_W-1:0] r_cnt;     // length of that run, saturates at DEB_CYCLES
        logic             r_stable;  // accepted (debounced) pressed level
        logic             r_evt;
        logic             w_smp;

        assign w_smp = r_sync[1];

        always_ff @(posedge CLOCK_50) begin
            if (!reset) begin
                r_sync   <= '0;
                r_last   <= 1'b0;
                r_cnt    <= DEB_FULL;
                r_stable <= 1'b0;
                r_evt    <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_btn_pin[gi] ^ BTN_ACTIVE_LOW};

                // A new level starts a fresh run counting this sample as the first.
                if (w_smp != r_last) begin
                    r_last <= w_smp;
                    r_cnt  <= DEB_W'(1);
                end else if (r_cnt != DEB_FULL) begin
                    r_cnt <= r_cnt + 1'b1;
                end

                // Accept the run level once it has lasted DEB_CYCLES samples;
                // only the not-pressed -> pressed acceptance is an event.
                if ((r_cnt == DEB_FULL) && (r_stable != r_last)) begin
                    r_stable <= r_last;
                    r_evt    <= r_last;
                end else begin
                    r_evt <= 1'b0;
                end
            end
        end

        assign w_btn_evt[gi] = r_evt;
    end

    logic w_move_evt;
    logic w_select_evt;

    assign w_move_evt   = w_btn_evt[0];
    assign w_select_evt = w_btn_evt[1];

    // ------------------------------------------------------------------- FSM
    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_selected;
    logic [FRM_W-1:0] r_frames;
    logic             r_counting;
    logic             r_finish;
    logic             r_timeout;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_selected <= '0;
            r_frames   <= '0;
            r_counting <= 1'b0;
            r_finish   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // select has priority; a simultaneous move is dropped.
                    if (w_select_evt) begin
                        r_state    <= ST_COUNTING;
                        r_frames   <= '0;
                        r_counting <= 1'b1;
                    end else if (w_move_evt) begin
                        r_selected <= (r_selected == SEL_LAST) ? '0 : r_selected + 1'b1;
                    end
                end
                ST_COUNTING: begin
                    // A user stop beats an expiry arriving on the same edge.
                    if (w_select_evt) begin
                        r_state    <= ST_DONE;
                        r_finish   <= 1'b1;
                        r_counting <= 1'b0;
                    end else if (w_frame_start) begin
                        r_frames <= r_frames + 1'b1;
                        if (r_frames == FRAMES_LAST) begin
                            r_state    <= ST_TIMEOUT;
                            r_timeout  <= 1'b1;
                            r_counting <= 1'b0;
                        end
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    if (w_select_evt) begin
                        r_state   <= ST_IDLE;
                        r_finish  <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.selected       = r_selected;
    assign bus.counting       = r_counting;
    assign bus.finish         = r_finish;
    assign bus.finish_timeout = r_timeout;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_vga_menu_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_menu_controller
//   Directed bench on a reduced raster: CLK_DIV=2, H 8/2/3/3 (H_TOTAL 16),
//   V 6/1/2/1 (V_TOTAL 10), so a frame is 160 pixels = 320 clocks.
//   DEB_CYCLES=4, N_OPTIONS=9, TIMEOUT_FRAMES=3, active-low buttons.
// ---------------------------------------------------------------------------
module tb_vga_menu_controller;
    import vga_pkg::*;

    localparam int H_TOTAL   = 16;
    localparam int V_TOTAL   = 10;
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL * 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   lat;

    vga_menu_controller_if #(.HW(4), .VW(4), .SEL_W(4)) vif ();

    vga_menu_controller #(
        .CLK_DIV        (2),
        .H_ACTIVE       (8),
        .H_FP           (2),
        .H_SYNC         (3),
        .H_BP           (3),
        .V_ACTIVE       (6),
        .V_FP           (1),
        .V_SYNC         (2),
        .V_BP           (1),
        .HS_POL         (1'b0),
        .VS_POL         (1'b0),
        .N_OPTIONS      (9),
        .DEB_CYCLES     (4),
        .BTN_ACTIVE_LOW (1'b1),
        .TIMEOUT_FRAMES (3)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (vif)
    );

    // ------------------------------------------------------ clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 = move, 1 = select, 2 = both
    task automatic press(input int which);
        if (which != 1) vif.move = 1'b0;
        if (which != 0) vif.select = 1'b0;
        ticks(12);
        vif.move   = 1'b1;
        vif.select = 1'b1;
        ticks(12);
    endtask

    task automatic wait_fs(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (vif.frame_start !== 1'b1 && k < 400);
        chk(tag, vif.frame_start, 1);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, " hcount"},      vif.hcount, 0);
        chk({pfx, " vcount"},      vif.vcount, 0);
        chk({pfx, " VGA_CLK"},     vif.VGA_CLK, 0);
        chk({pfx, " BLANK_N"},     vif.VGA_BLANK_N, 0);
        chk({pfx, " frame_start"}, vif.frame_start, 0);
        chk({pfx, " HS"},          vif.VGA_HS, 1);
        chk({pfx, " VS"},          vif.VGA_VS, 1);
        chk({pfx, " SYNC_N"},      vif.VGA_SYNC_N, 0);
        chk({pfx, " selected"},    vif.selected, 0);
        chk({pfx, " counting"},    vif.counting, 0);
        chk({pfx, " finish"},      vif.finish, 0);
        chk({pfx, " timeout"},     vif.finish_timeout, 0);
        chk({pfx, " state"},       vif.dbg_state, IDLE);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int blank_cnt, hs_low_cnt, vs_low_cnt, fs_cnt, fs_first, fs_last;
        n_checks   = 0;
        n_errors   = 0;
        lat        = 0;
        vif.move   = 1'b1;
        vif.select = 1'b1;
        rst_n      = 1'b0;
        ticks(3);
        chk_reset_values("reset");
        rst_n = 1'b1;

        // T1/T2: two frames against a pixel-index model.
        blank_cnt  = 0;
        hs_low_cnt = 0;
        vs_low_cnt = 0;
        fs_cnt     = 0;
        fs_first   = 0;
        fs_last    = 0;
        for (int n = 1; n <= 2 * FRAME_CYC; n++) begin
            int p, eh, ev;
            tick();
            p  = n / 2;
            eh = p % H_TOTAL;
            ev = (p / H_TOTAL) % V_TOTAL;
            chk("T2 hcount",  vif.hcount, eh);
            chk("T2 vcount",  vif.vcount, ev);
            chk("T1 HS",      vif.VGA_HS, (eh >= 10 && eh <= 12) ? 0 : 1);
            chk("T1 VS",      vif.VGA_VS, (ev >= 7 && ev <= 8) ? 0 : 1);
            chk("T2 BLANK_N", vif.VGA_BLANK_N, (eh < 8 && ev < 6) ? 1 : 0);
            chk("T1 VGA_CLK", vif.VGA_CLK, n % 2);
            chk("T1 frame_start", vif.frame_start, (n % FRAME_CYC == 0) ? 1 : 0);
            if (vif.VGA_HS === 1'b0) hs_low_cnt++;
            if (vif.VGA_VS === 1'b0) vs_low_cnt++;
            if (n > FRAME_CYC && vif.VGA_BLANK_N === 1'b1) blank_cnt++;
            if (vif.frame_start === 1'b1) begin
                if (fs_cnt == 0) fs_first = n;
                fs_last = n;
                fs_cnt++;
            end
        end
        chk("T2 blank cycles per frame", blank_cnt, 8 * 6 * 2);
        chk("T1 HS low cycles",          hs_low_cnt, 3 * 2 * 20);
        chk("T1 VS low cycles",          vs_low_cnt, 2 * 2 * 16 * 2);
        chk("T1 frame_start count",      fs_cnt, 2);
        chk("T1 frame_start period",     fs_last - fs_first, FRAME_CYC);

        // T3: glitch rejection, then cursor walk with wrap.
        vif.move = 1'b0;
        ticks(3);
        vif.move = 1'b1;
        ticks(20);
        chk("T3 glitch selected", vif.selected, 0);

        vif.move = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (vif.selected === 4'd0 && lat < 30);
        vif.move = 1'b1;
        ticks(12);
        chk("T3 press 1 selected", vif.selected, 1);
        chk("T3 press latency in range", (lat >= 6 && lat <= 12) ? 1 : 0, 1);
        for (int k = 2; k <= 9; k++) begin
            press(0);
            chk("T3 press selected", vif.selected, k % 9);
        end
        press(0);
        press(0);
        chk("T3 selected=2", vif.selected, 2);

        // T4: countdown expiry on the third frame_start.
        wait_fs("T4 sync frame");
        press(1);
        chk("T4 counting",  vif.counting, 1);
        chk("T4 state",     vif.dbg_state, COUNTING);
        wait_fs("T4 frame 1");
        wait_fs("T4 frame 2");
        chk("T4 counting after 2 frames", vif.counting, 1);
        wait_fs("T4 frame 3");
        chk("T4 timeout before edge", vif.finish_timeout, 0);
        tick();
        chk("T4 finish_timeout", vif.finish_timeout, 1);
        chk("T4 counting off",   vif.counting, 0);
        chk("T4 finish",         vif.finish, 0);
        chk("T4 state",          vif.dbg_state, TIMEOUT);
        chk("T4 selected",       vif.selected, 2);
        press(1);
        chk("T4 ack timeout",    vif.finish_timeout, 0);
        chk("T4 ack state",      vif.dbg_state, IDLE);

        // T5a: user stop, move ignored, acknowledge.
        wait_fs("T5 sync frame");
        press(1);
        chk("T5 counting", vif.counting, 1);
        press(1);
        chk("T5 finish",   vif.finish, 1);
        chk("T5 counting off", vif.counting, 0);
        chk("T5 timeout",  vif.finish_timeout, 0);
        press(0);
        chk("T5 move ignored in DONE", vif.selected, 2);
        press(1);
        chk("T5 ack finish",   vif.finish, 0);
        chk("T5 ack timeout",  vif.finish_timeout, 0);
        chk("T5 ack counting", vif.counting, 0);
        chk("T5 ack selected", vif.selected, 2);

        // T5b: select event lands on the same edge as the final frame_start.
        wait_fs("T5b sync frame");
        press(1);
        chk("T5b counting", vif.counting, 1);
        wait_fs("T5b frame 1");
        wait_fs("T5b frame 2");
        ticks(FRAME_CYC + 1 - lat);
        vif.select = 1'b0;
        ticks(12);
        vif.select = 1'b1;
        ticks(12);
        chk("T5b finish",   vif.finish, 1);
        chk("T5b timeout",  vif.finish_timeout, 0);
        chk("T5b counting", vif.counting, 0);
        chk("T5b state",    vif.dbg_state, DONE);
        wait_fs("T5b later frame");
        tick();
        chk("T5b timeout held 0", vif.finish_timeout, 0);
        press(1);
        chk("T5b ack finish", vif.finish, 0);

        // T6: reset mid-count, then simultaneous move+select in IDLE.
        wait_fs("T6 sync frame");
        press(1);
        ticks(37);
        chk("T6 counting before reset", vif.counting, 1);
        chk("T6 mid-line", (vif.hcount != 0) ? 1 : 0, 1);
        rst_n = 1'b0;
        tick();
        chk_reset_values("T6 reset");
        ticks(2);
        rst_n = 1'b1;
        ticks(4);
        press(2);
        chk("T6 both counting", vif.counting, 1);
        chk("T6 both selected", vif.selected, 0);
        chk("T6 both state",    vif.dbg_state, COUNTING);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
